// File: rtl/binarisation_pkg.sv
// rtl/binarisation_pkg.sv - shared constants and component slicing for the YCbCr binariser
package binarisation_pkg;

  localparam int CH_Y  = 2;
  localparam int CH_CB = 1;
  localparam int CH_CR = 0;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 22;

  // Widest component the slicing helper supports; callers truncate to their own W.
  localparam int COMP_MAX = 16;

  function automatic logic [COMP_MAX-1:0] comp_of(
    input logic [3*COMP_MAX-1:0] bus,
    input int unsigned           w,
    input int unsigned           ch
  );
    return COMP_MAX'(bus >> (ch * w));
  endfunction

endpackage

// File: rtl/bin_range_cmp.sv
// rtl/bin_range_cmp.sv - per-channel window test; a disabled channel always passes
module bin_range_cmp #(
  parameter int W         = 8,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] low,
  input  logic [W-1:0] high,
  input  logic         en,
  output logic         pass
);

  logic in_win;

  // An inverted window (low > high) can never hold in either compare mode.
  always_comb begin
    in_win = 1'b0;
    if (INCLUSIVE)
      in_win = (x >= low) && (x <= high);
    else
      in_win = (x > low) && (x < high);
  end

  assign pass = ~en | in_win;

endmodule

// File: rtl/binarisation_rt.sv
// rtl/binarisation_rt.sv - two-stage YCbCr colour-key binariser with frame-buffered windows and fg count
module binarisation_rt
  import binarisation_pkg::*;
#(
  parameter int           W         = DEF_W,
  parameter int           CNT_W     = DEF_CNT_W,
  parameter bit           INCLUSIVE = 1'b0,
  parameter logic [W-1:0] Y_LOW     = '0,
  parameter logic [W-1:0] Y_HIGH    = '1,
  parameter logic [W-1:0] CB_LOW    = W'(100),
  parameter logic [W-1:0] CB_HIGH   = W'(140),
  parameter logic [W-1:0] CR_LOW    = '0,
  parameter logic [W-1:0] CR_HIGH   = '1,
  parameter logic [2:0]   EN_RST    = 3'b110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic [3*W-1:0]   pixel_in,
  input  logic             cfg_wr,
  input  logic [W-1:0]     cfg_y_low,
  input  logic [W-1:0]     cfg_y_high,
  input  logic [W-1:0]     cfg_cb_low,
  input  logic [W-1:0]     cfg_cb_high,
  input  logic [W-1:0]     cfg_cr_low,
  input  logic [W-1:0]     cfg_cr_high,
  input  logic [2:0]       cfg_en,
  input  logic             cfg_invert,
  output logic             de_out,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic [3*W-1:0]   pixel_out,
  output logic             mask_out,
  output logic [CNT_W-1:0] fg_count,
  output logic             fg_count_valid
);

  localparam logic [W-1:0] LOW_RST  [3] = '{CR_LOW,  CB_LOW,  Y_LOW};
  localparam logic [W-1:0] HIGH_RST [3] = '{CR_HIGH, CB_HIGH, Y_HIGH};

  logic [W-1:0] low_pend [3];
  logic [W-1:0] high_pend [3];
  logic [W-1:0] low_act [3];
  logic [W-1:0] high_act [3];
  logic [2:0]   en_pend, en_act;
  logic         inv_pend, inv_act;
  logic         vs_in_prev;
  logic         vs_rise;

  assign vs_rise = v_sync_in & ~vs_in_prev;

  // Pending is updated by writes; active only copies pending on a v_sync_in rise,
  // so a write landing on that same cycle waits for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low_pend   <= LOW_RST;
      high_pend  <= HIGH_RST;
      low_act    <= LOW_RST;
      high_act   <= HIGH_RST;
      en_pend    <= EN_RST;
      en_act     <= EN_RST;
      inv_pend   <= 1'b0;
      inv_act    <= 1'b0;
      vs_in_prev <= 1'b0;
    end else begin
      vs_in_prev <= v_sync_in;
      if (cfg_wr) begin
        low_pend[CH_Y]   <= cfg_y_low;
        high_pend[CH_Y]  <= cfg_y_high;
        low_pend[CH_CB]  <= cfg_cb_low;
        high_pend[CH_CB] <= cfg_cb_high;
        low_pend[CH_CR]  <= cfg_cr_low;
        high_pend[CH_CR] <= cfg_cr_high;
        en_pend          <= cfg_en;
        inv_pend         <= cfg_invert;
      end
      if (vs_rise) begin
        low_act  <= low_pend;
        high_act <= high_pend;
        en_act   <= en_pend;
        inv_act  <= inv_pend;
      end
    end
  end

  logic [2:0] pass_c;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [W-1:0] x;
    assign x = W'(comp_of((3*COMP_MAX)'(pixel_in), W, ch));
    bin_range_cmp #(.W(W), .INCLUSIVE(INCLUSIVE)) u_cmp (
      .x    (x),
      .low  (low_act[ch]),
      .high (high_act[ch]),
      .en   (en_act[ch]),
      .pass (pass_c[ch])
    );
  end

  logic [2:0] pass1;
  logic       de1, hs1, vs1, inv1;

  // Invert travels with the pixel so a frame-boundary swap cannot split a pixel's config.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass1      <= '0;
      de1        <= 1'b0;
      hs1        <= 1'b0;
      vs1        <= 1'b0;
      inv1       <= 1'b0;
      mask_out   <= 1'b0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      pass1      <= pass_c;
      de1        <= de_in;
      hs1        <= h_sync_in;
      vs1        <= v_sync_in;
      inv1       <= inv_act;
      mask_out   <= de1 & ((&pass1) ^ inv1);
      de_out     <= de1;
      h_sync_out <= hs1;
      v_sync_out <= vs1;
    end
  end

  assign pixel_out = {(3*W){mask_out}};

  logic [CNT_W-1:0] cnt, cnt_sum;
  logic             vs_out_prev, frame_end, armed;

  assign frame_end = v_sync_out & ~vs_out_prev;

  always_comb begin
    cnt_sum = cnt;
    if (de_out && mask_out && (cnt != {CNT_W{1'b1}}))
      cnt_sum = cnt + CNT_W'(1);
  end

  // armed stays low until the first frame boundary after reset, so a partial frame is never reported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      fg_count       <= '0;
      fg_count_valid <= 1'b0;
      vs_out_prev    <= 1'b0;
      armed          <= 1'b0;
    end else begin
      vs_out_prev    <= v_sync_out;
      fg_count_valid <= 1'b0;
      if (frame_end) begin
        cnt   <= '0;
        armed <= 1'b1;
        if (armed) begin
          fg_count       <= cnt_sum;
          fg_count_valid <= 1'b1;
        end
      end else begin
        cnt <= cnt_sum;
      end
    end
  end

endmodule

// File: doc/binarisation_rt.md
Name: binarisation_rt

Overview:
Next-generation colour-key binariser for the YCbCr video path. It is parametrised in component width and has runtime-programmable per-channel windows on Y, Cb and Cr, with per-channel enables, an invert mode and an inclusive/strict compare option. Threshold writes are double-buffered and take effect only at a frame boundary. The block is pipelined (registered outputs) and reports a per-frame foreground pixel count for downstream centroid and AGC logic.

Parameters:
W, 8, bits per colour component; pixel bus is 3*W (Y in [3W-1:2W], Cb in [2W-1:W], Cr in [W-1:0]).
CNT_W, 22, width of the foreground pixel counter.
INCLUSIVE, 0, 0 = strict compare (low < x < high); 1 = inclusive (low <= x <= high).
Y_LOW/Y_HIGH, 0/all-ones, reset window for Y.
CB_LOW/CB_HIGH, 100/140, reset window for Cb.
CR_LOW/CR_HIGH, 0/all-ones, reset window for Cr.
EN_RST, 3'b110, reset channel-enable mask, as {Y, Cb, Cr}.

Ports:
clk  in  1  pixel clock.
rst_n  in  1  synchronous reset, active low.
de_in, h_sync_in, v_sync_in  in  1 each  input video timing.
pixel_in  in  3W  YCbCr pixel.
cfg_wr  in  1  one-cycle write strobe; loads all cfg_* fields into the pending registers.
cfg_y_low, cfg_y_high, cfg_cb_low, cfg_cb_high, cfg_cr_low, cfg_cr_high  in  W each  window bounds.
cfg_en  in  3  channel enables {Y, Cb, Cr}.
cfg_invert  in  1  1 = output the complement of the mask.
de_out, h_sync_out, v_sync_out  out  1 each  timing, delayed by 2 cycles.
pixel_out  out  3W  mask bit replicated to all 3W bits.
mask_out  out  1  the same mask as a single bit.
fg_count  out  CNT_W  foreground count of the last completed frame.
fg_count_valid  out  1  one-cycle pulse when fg_count updates.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all outputs go to 0;
  - pending and active registers load the parameter defaults, invert=0;
  - the counter clears and the sync edge detectors clear.
- Latency: exactly 2 cycles, input to output, for the pixel and all three timing signals. There is no backpressure.
- Stage 1 (registered): per channel, pass_c = !en_c OR in-window(x_c). Window test uses strict or inclusive compare per INCLUSIVE, against the active registers.
- Stage 2 (registered): mask = (pass_Y & pass_Cb & pass_Cr) XOR invert.
  - Forced to 0 when the stage-1 de is low; invert never sets blanking pixels.
  - pixel_out = {3W{mask}}.
- Inverted window (low > high) is never satisfied, so an enabled channel with an inverted window yields pass=0. All channels disabled gives mask=1 during de (0 if invert=1).
- Config double-buffering:
  - cfg_wr updates the pending registers only; the last write before a frame boundary wins.
  - Active registers load from pending on the cycle v_sync_in rises (v_sync_in=1 and previous-cycle v_sync_in=0).
  - The pixel sampled into stage 1 on that same cycle still uses the old active values.
  - If cfg_wr coincides with the v_sync_in rising edge, active takes the pending value from before the write. The new write is applied at the next frame boundary.
- Foreground counter:
  - Increments when stage-2 de and mask are both 1.
  - Saturates at 2^CNT_W-1 (no wrap).
- Frame end is the rising edge of v_sync_out, the delayed sync. On that cycle:
  - fg_count <= counter value including any pixel counted that cycle;
  - fg_count_valid = 1 for one cycle;
  - counter clears to 0.
- Reset mid-frame discards the partial count. No fg_count_valid pulse follows until a full v_sync_out rising edge after reset.
- h_sync is pass-through (delayed only); it has no effect on state.

Decomposition:
- Package binarisation_pkg holds:
  - channel index constants (CH_Y=2, CH_CB=1, CH_CR=0);
  - the default W and CNT_W;
  - the function that slices a component out of the 3W bus.
- Sub-module bin_range_cmp (param W, INCLUSIVE): combinational window test on x, low, high and en, giving pass. It is instantiated 3 times in stage 1.

Test Plan:
1. Reset defaults, W=8, strict. Drive pixel {Y=50, Cb=120, Cr=200} with de=1 → mask_out=1 and pixel_out=24'hFFFFFF two cycles later. Cb=100 → mask 0 (strict boundary). With INCLUSIVE=1, Cb=100 → mask 1.
2. cfg_wr mid-frame with cb window 10..20 → the current frame still uses 100..140. After the next v_sync_in rise, Cb=15 gives mask 1 and Cb=120 gives mask 0.
3. cfg_wr on the exact v_sync_in rising cycle → the old pending value is applied now; the new value is applied one frame later.
4. Frame of 64 de pixels, 10 of them in-window → on the v_sync_out rise, fg_count=10 with a 1-cycle fg_count_valid. The next frame's count starts from 0.
5. CNT_W=4, 20 in-window pixels → fg_count=15 (saturated). cfg_invert=1 with de=0 → pixel_out stays 0.
6. rst_n low for one cycle mid-frame → all outputs 0 on the next cycle, active thresholds back to defaults, no fg_count_valid at the following v_sync edge.
